// File: rtl/fib_sched_pkg.sv
// Shared types and default widths for the fib scheduler and its arbiter.
package fib_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } fib_sched_state_e;

    localparam int FIB_IDX_W = 5;
    localparam int FIB_RES_W = 20;

endpackage

// File: rtl/fib_sched_rr_arbiter.sv
// Combinational round-robin arbiter: lowest requester above last_grant wins,
// otherwise the lowest requester overall (wrap-around).
module rr_arbiter
    import fib_sched_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic [N-1:0] upper;
    logic [N-1:0] masked;
    logic [N-1:0] pick;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_mask
            assign upper[gi] = (IW'(gi) > last_grant);
        end
    endgenerate

    assign masked = req & upper;
    assign pick   = (|masked) ? masked : req;
    // Isolate the lowest set bit of the chosen vector.
    assign grant  = pick & (~pick + N'(1));

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                grant_idx = grant_idx | IW'(i);
            end
        end
    end

endmodule

// File: rtl/fib_sched.sv
// Shares one fib unit among N_REQ requesters: grant, start, wait for done
// (or timeout), then pulse a one-cycle response to the granted requester.
module fib_sched
    import fib_sched_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int IDX_W   = FIB_IDX_W,
    parameter int RES_W   = FIB_RES_W,
    parameter int TIMEOUT = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ-1:0][IDX_W-1:0] req_idx,
    output logic [N_REQ-1:0]            req_ready,
    output logic [N_REQ-1:0]            rsp_valid,
    output logic [RES_W-1:0]            rsp_result,
    output logic                        rsp_err,
    output logic [IDX_W-1:0]            fib_i,
    output logic                        fib_start,
    input  logic                        fib_done,
    input  logic [RES_W-1:0]            fib_result,
    output logic                        busy
);

    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    fib_sched_state_e state_reg;
    logic [GW-1:0]    last_grant_reg;
    logic [GW-1:0]    gnt_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [CW-1:0]    cnt_reg;
    logic [RES_W-1:0] res_reg;
    logic             err_reg;

    logic [N_REQ-1:0] arb_grant;
    logic [GW-1:0]    arb_idx;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req        (req_valid),
        .last_grant (last_grant_reg),
        .grant      (arb_grant),
        .grant_idx  (arb_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            last_grant_reg <= GW'(N_REQ - 1);
            gnt_reg        <= '0;
            idx_reg        <= '0;
            cnt_reg        <= '0;
            res_reg        <= '0;
            err_reg        <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // The grant is always one of the valid requesters, so any
                    // valid bit means a handshake on this edge.
                    if (|req_valid) begin
                        idx_reg        <= req_idx[arb_idx];
                        gnt_reg        <= arb_idx;
                        last_grant_reg <= arb_idx;
                        state_reg      <= START;
                    end
                end
                START: begin
                    cnt_reg   <= '0;
                    state_reg <= WAIT;
                end
                WAIT: begin
                    cnt_reg <= cnt_reg + CW'(1);
                    // cnt_reg == 0 marks the first WAIT cycle, where done may be stale.
                    if (fib_done && (cnt_reg != '0)) begin
                        res_reg   <= fib_result;
                        err_reg   <= 1'b0;
                        state_reg <= RESP;
                    end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
                        res_reg   <= '0;
                        err_reg   <= 1'b1;
                        state_reg <= RESP;
                    end
                end
                RESP: begin
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign req_ready  = (state_reg == IDLE) ? arb_grant : '0;
    assign rsp_result = (state_reg == RESP) ? res_reg : '0;
    assign rsp_err    = (state_reg == RESP) ? err_reg : 1'b0;
    assign fib_i      = idx_reg;
    assign fib_start  = (state_reg == START);
    assign busy       = (state_reg != IDLE);

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_rsp
            assign rsp_valid[gi] = (state_reg == RESP) && (gnt_reg == GW'(gi));
        end
    endgenerate

endmodule

// File: tb/tb_fib_sched.sv
// Directed bench for fib_sched with a behavioural fib unit and a cycle-level
// reference model of grants, start pulses and response timing.
module tb_fib_sched;

    localparam int N       = 4;
    localparam int IDX_W   = 5;
    localparam int RES_W   = 20;
    localparam int TIMEOUT = 64;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [N-1:0]            req_valid;
    logic [N-1:0][IDX_W-1:0] req_idx;
    logic [N-1:0]            req_ready;
    logic [N-1:0]            rsp_valid;
    logic [RES_W-1:0]        rsp_result;
    logic                    rsp_err;
    logic [IDX_W-1:0]        fib_i;
    logic                    fib_start;
    logic                    fib_done;
    logic [RES_W-1:0]        fib_result;
    logic                    busy;

    int checks   = 0;
    int failures = 0;

    fib_sched #(.N_REQ(N), .IDX_W(IDX_W), .RES_W(RES_W), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_idx    (req_idx),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .fib_i      (fib_i),
        .fib_start  (fib_start),
        .fib_done   (fib_done),
        .fib_result (fib_result),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [RES_W-1:0] fib_ref(input int n);
        logic [RES_W-1:0] a, b, t;
        a = '0;
        b = RES_W'(1);
        for (int k = 0; k < n; k++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    // Behavioural fib unit: done rises fib_lat cycles into WAIT and stays high
    // until the next start; the first WAIT cycle still shows the stale done.
    bit               fib_hang = 1'b0;
    int               fib_lat  = 1;
    bit               fm_active;
    bit               fm_stale;
    int               fm_cnt;
    logic [IDX_W-1:0] fm_idx;
    logic [RES_W-1:0] fm_prev;

    always @(posedge clk) begin
        if (rst) begin
            fm_active <= 1'b0;
            fm_stale  <= 1'b0;
            fm_cnt    <= 0;
            fm_idx    <= '0;
            fm_prev   <= '0;
        end else if (fib_start) begin
            fm_active <= 1'b1;
            fm_cnt    <= 0;
            fm_stale  <= fib_done;
            fm_prev   <= fib_result;
            fm_idx    <= fib_i;
        end else if (fm_active) begin
            fm_cnt <= fm_cnt + 1;
        end
    end

    always_comb begin
        fib_done   = 1'b0;
        fib_result = RES_W'(20'h5A5A5);
        if (fm_active) begin
            if (fm_cnt == 0) begin
                fib_done   = fm_stale;
                fib_result = fm_prev;
            end else if (!fib_hang && fm_cnt >= fib_lat) begin
                fib_done   = 1'b1;
                fib_result = fib_ref(int'(fm_idx));
            end
        end
    end

    // Response log built from DUT outputs, for the literal expectations.
    int               log_n = 0;
    int               log_req [64];
    logic [RES_W-1:0] log_res [64];
    bit               log_err [64];
    int               log_lat [64];
    int               cyc = 0;

    // Reference model and per-cycle comparison, sampled on the falling edge.
    initial begin
        int               idle_from = 0;
        int               last      = N - 1;
        bit               pend      = 1'b0;
        int               p_g = 0, p_hs = 0, p_rsp = 0, hs_act = 0;
        bit               p_err = 1'b0;
        logic [RES_W-1:0] p_res = '0;
        logic [IDX_W-1:0] m_fib_i = '0;
        logic [N-1:0]     exp_ready, exp_rsp;
        int               g;
        forever begin
            @(negedge clk);
            cyc++;
            if ((req_valid & req_ready) != '0) hs_act = cyc;
            if (rsp_valid != '0 && log_n < 64) begin
                log_req[log_n] = $clog2(int'(rsp_valid));
                log_res[log_n] = rsp_result;
                log_err[log_n] = rsp_err;
                log_lat[log_n] = cyc - hs_act;
                log_n++;
            end
            if (rst) begin
                pend      = 1'b0;
                idle_from = cyc + 1;
                last      = N - 1;
                m_fib_i   = '0;
            end else begin
                exp_ready = '0;
                g = -1;
                if (cyc >= idle_from && req_valid != '0) begin
                    g = rr_pick(req_valid, last);
                    exp_ready = N'(1) << g;
                end
                check("req_ready", req_ready, exp_ready);
                check("ready_onehot", $countones(req_ready) <= 1, 1);
                check("busy", busy, cyc < idle_from);
                check("fib_start", fib_start, pend && cyc == p_hs + 1);
                check("fib_i", fib_i, m_fib_i);
                exp_rsp = (pend && cyc == p_rsp) ? (N'(1) << p_g) : '0;
                check("rsp_valid", rsp_valid, exp_rsp);
                if (exp_rsp != '0) begin
                    check("rsp_result", rsp_result, p_res);
                    check("rsp_err", rsp_err, p_err);
                    pend = 1'b0;
                end
                if (g >= 0) begin
                    pend      = 1'b1;
                    p_g       = g;
                    p_hs      = cyc;
                    p_err     = fib_hang || fib_lat >= TIMEOUT;
                    p_rsp     = p_err ? cyc + TIMEOUT + 2 : cyc + 3 + fib_lat;
                    p_res     = p_err ? '0 : fib_ref(int'(req_idx[g]));
                    idle_from = p_rsp + 1;
                    last      = g;
                    m_fib_i   = req_idx[g];
                end
            end
        end
    end

    task automatic issue(input int r, input int idx);
        bit ok = 1'b0;
        @(posedge clk); #1;
        req_idx[r]   = IDX_W'(idx);
        req_valid[r] = 1'b1;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            if (req_ready[r]) ok = 1'b1;
        end
        @(posedge clk); #1;
        req_valid[r] = 1'b0;
        check("grant_seen", ok, 1);
    endtask

    task automatic wait_rsp(input int n);
        bit ok = 1'b0;
        for (int t = 0; t < 300 && !ok; t++) begin
            @(posedge clk);
            if (log_n >= n) ok = 1'b1;
        end
        check("rsp_arrived", ok, 1);
    endtask

    task automatic reset_pulse(input int n);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (n) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic check_reset_outputs();
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_result", rsp_result, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_fib_i", fib_i, 0);
        check("rst_fib_start", fib_start, 0);
    endtask

    initial begin
        int           b;
        logic [N-1:0] gset;
        rst       = 1'b1;
        req_valid = '0;
        req_idx   = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_reset_outputs();

        // Single request, slow fib.
        b = log_n;
        fib_lat = 3;
        issue(0, 9);
        wait_rsp(b + 1);
        check("t1_req", log_req[b], 0);
        check("t1_res", log_res[b], 34);
        check("t1_err", log_err[b], 0);
        check("t1_lat_min4", log_lat[b] >= 4, 1);

        // All four at once after reset, fastest fib.
        reset_pulse(2);
        b = log_n;
        fib_lat = 1;
        @(posedge clk); #1;
        for (int r = 0; r < N; r++) req_idx[r] = IDX_W'(r);
        req_valid = '1;
        for (int t = 0; t < 100 && req_valid != '0; t++) begin
            @(negedge clk);
            gset = req_ready & req_valid;
            @(posedge clk); #1;
            req_valid = req_valid & ~gset;
        end
        wait_rsp(b + 4);
        for (int k = 0; k < 4; k++) begin
            check("t2_order", log_req[b + k], k);
            check("t2_res", log_res[b + k], (k == 3) ? 2 : (k == 0 ? 0 : 1));
        end
        check("t2_lat4", log_lat[b], 4);

        // Two continuous requesters alternate.
        b = log_n;
        @(posedge clk); #1;
        req_idx[1] = IDX_W'(7);
        req_idx[2] = IDX_W'(8);
        req_valid  = 4'b0110;
        wait_rsp(b + 4);
        #1 req_valid = '0;
        for (int k = 0; k < 4; k++) begin
            check("t3_req", log_req[b + k], (k % 2 == 0) ? 1 : 2);
            check("t3_res", log_res[b + k], (k % 2 == 0) ? 13 : 21);
        end

        // Largest index that fits the result width.
        b = log_n;
        issue(3, 30);
        wait_rsp(b + 1);
        check("t4_res", log_res[b], 832040);

        // Hung fib: timeout, then recovery.
        b = log_n;
        fib_hang = 1'b1;
        issue(0, 5);
        wait_rsp(b + 1);
        check("t5_err", log_err[b], 1);
        check("t5_res", log_res[b], 0);
        check("t5_lat", log_lat[b], 66);
        fib_hang = 1'b0;
        issue(0, 5);
        wait_rsp(b + 2);
        check("t5_recover_res", log_res[b + 1], 5);
        check("t5_recover_err", log_err[b + 1], 0);

        // Done on the last WAIT cycle wins over timeout; one cycle later loses.
        b = log_n;
        fib_lat = TIMEOUT - 1;
        issue(1, 4);
        wait_rsp(b + 1);
        check("tb_edge_res", log_res[b], 3);
        check("tb_edge_err", log_err[b], 0);
        check("tb_edge_lat", log_lat[b], 66);
        fib_lat = TIMEOUT;
        issue(2, 4);
        wait_rsp(b + 2);
        check("tb_late_err", log_err[b + 1], 1);
        check("tb_late_res", log_res[b + 1], 0);

        // Reset while waiting: no response, clean restart.
        fib_lat = 20;
        issue(0, 9);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        b = log_n;
        check_reset_outputs();
        repeat (30) @(posedge clk);
        check("t6_no_rsp", log_n, b);
        fib_lat = 1;
        issue(0, 6);
        wait_rsp(b + 1);
        check("t6_req", log_req[b], 0);
        check("t6_res", log_res[b], 8);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fib_sched.md
# fib_sched

Round-robin scheduler that shares one `fib` unit among `N_REQ` requesters. It accepts one index request at a time through a valid/ready handshake and sequences the `fib` start/done protocol. It then returns the result, or a timeout error, to the granted requester. It sits between requester blocks and the single `fib` instance, and drives all of that instance's inputs except clock and reset.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters; must be 2 or more.
- `IDX_W`, 5: width of the Fibonacci index.
- `RES_W`, 20: width of the result.
- `TIMEOUT`, 64: maximum number of WAIT cycles before an error response is returned.

Ports:
- `clk`, input, 1: the single clock.
- `rst`, input, 1: reset, synchronous and active-high.
- `req_valid`, input, `N_REQ`: per-requester request.
- `req_idx`, input, `N_REQ`×`IDX_W`: per-requester index; must be stable while `req_valid` is high.
- `req_ready`, output, `N_REQ`: one-hot grant; the handshake completes on a clock edge where `req_valid[g]` and `req_ready[g]` are both high.
- `rsp_valid`, output, `N_REQ`: one-hot, one-cycle response pulse.
- `rsp_result`, output, `RES_W`: result, valid only while `rsp_valid` is nonzero.
- `rsp_err`, output, 1: timeout flag, valid only while `rsp_valid` is nonzero.
- `fib_i`, output, `IDX_W`: index to `fib`.
- `fib_start`, output, 1: start pulse to `fib`.
- `fib_done`, input, 1: completion signal from `fib`.
- `fib_result`, input, `RES_W`: result from `fib`, valid in any cycle where `fib_done` is high.
- `busy`, output, 1: high in every state except IDLE.

## Operation
- FSM states: IDLE, START, WAIT, RESP. Reset state is IDLE.
- **IDLE**
  - If any `req_valid` bit is high, the arbiter chooses winner `g`.
  - `req_ready[g]` is driven combinationally high; all other `req_ready` bits are 0.
  - On the handshake edge: latch `req_idx[g]` into `fib_i`, latch `g`, set `last_grant` to `g`, and go to START.
- **START**
  - `fib_start` is 1 for exactly this cycle; `fib_i` holds the latched index.
  - Clear the timeout counter, then go to WAIT.
- **WAIT**
  - The timeout counter increments every cycle.
  - `fib_done` is ignored in the first WAIT cycle, because `fib` may still show done from the previous operation. From the second WAIT cycle on, `fib_done` is honoured.
  - On `fib_done` = 1: capture `fib_result`, set the error flag to 0, go to RESP.
  - Else, if the counter reaches `TIMEOUT`: set the captured result to 0, set the error flag to 1, go to RESP.
  - If `fib_done` and the timeout occur in the same cycle, `fib_done` wins.
- **RESP**
  - `rsp_valid[g]` = 1 for one cycle, with `rsp_result` and `rsp_err` driven from the captured values.
  - Responses have no backpressure. Go to IDLE.
- **Arbitration**
  - Round-robin. Search starts at `(last_grant+1) mod N_REQ` and wraps around.
  - `last_grant` resets to `N_REQ-1`, so requester 0 has first priority after reset.
  - Requests arriving while `busy` is high wait; `req_ready` stays 0 for all requesters.
  - A requester may drop `req_valid` before it is granted; no state is kept for it.
- **Widths:** no arithmetic is done on the result; it passes through unchanged. Overflow (index above 30 for a 20-bit result) is `fib`'s behaviour and is passed through.

## Timing
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_result`=0, `rsp_err`=0, `fib_i`=0, `fib_start`=0, `busy`=0.
- Cycle numbering, with the handshake on edge 0:
  - `fib_start` is high in cycle 1.
  - WAIT begins in cycle 2.
  - If `fib_done` is first honoured in cycle k, `rsp_valid` is high in cycle k+1.
  - The next grant is possible at the earliest in cycle k+2.
- Minimum request-to-response latency: 4 cycles, with done honoured in cycle 3.
- Timeout: the error response appears `TIMEOUT`+1 cycles after the start cycle.
- Reset during any state:
  - The next cycle is IDLE with all outputs at their reset values.
  - The in-flight requester receives no response.
  - `fib` shares `rst`.

## Structure
- Package `fib_sched_pkg`:
  - state enum `fib_sched_state_e` with values IDLE, START, WAIT, RESP;
  - constants `FIB_IDX_W`=5 and `FIB_RES_W`=20, used as the parameter defaults.
- Sub-module `rr_arbiter`:
  - parameter `N`;
  - inputs `req[N]` and `last_grant`;
  - outputs a one-hot `grant` and its index;
  - purely combinational. The `last_grant` register stays in `fib_sched`.

## Test plan
- Requester 0 sends idx 9 → `rsp_valid`=4'b0001, `rsp_result`=34, `rsp_err`=0, at least 4 cycles after the handshake.
- After reset, all four requesters raise requests at once with idx 0, 1, 2, 3 → served in order 0, 1, 2, 3 with results 0, 1, 1, 2; `req_ready` is never multi-hot.
- Requester 1 requests idx 7 continuously and requester 2 requests idx 8 continuously → responses alternate 13, 21, 13, 21…; neither requester starves.
- Requester 3 sends idx 30 → `rsp_result`=832040.
- `fib` model holds `fib_done` low and requester 0 sends idx 5 → `rsp_err`=1 and `rsp_result`=0 exactly 65 cycles after `fib_start`; FSM returns to IDLE; a following idx 5 request with a working model returns 5.
- Assert `rst` for 1 cycle in WAIT → no `rsp_valid`, all outputs at reset values, and the next request from requester 0 (idx 6) returns 8.
